// File: rtl/wave_ctrl_pkg.sv
// Shared encodings for the waveform sequencer: FSM states, wave select codes, sweep direction.
package wave_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWEEP_UP   = 2'd1,
        ST_SWEEP_DOWN = 2'd2,
        ST_HOLD       = 2'd3
    } sweep_state_t;

    localparam logic [1:0] WAVE_SINE   = 2'b00;
    localparam logic [1:0] WAVE_TRI    = 2'b01;
    localparam logic [1:0] WAVE_SQUARE = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [1:0] next_wave(input logic [1:0] w);
        case (w)
            WAVE_SINE: return WAVE_TRI;
            WAVE_TRI:  return WAVE_SQUARE;
            default:   return WAVE_SINE;
        endcase
    endfunction

    // 2'b11 has no generator behind it, so it falls back to sine.
    function automatic logic [1:0] legal_wave(input logic [1:0] w);
        return (w == 2'b11) ? WAVE_SINE : w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse on a
// debounced high-to-low transition. Shared by the front-panel keys.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_s1, key_s2, key_level;
    logic [CW-1:0] cnt;

    // cnt holds the number of consecutive synced samples that disagree with key_level;
    // the level flips on the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            key_level <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                key_level <= key_s2;
                press     <= ~key_s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_sweep_ctrl.sv
// Frequency-sweep sequencer for the waveform datapath; settings are committed only on dac_done.
// WAVE_SWEEP_AUTO_WAVE_EN: wave target advances at each sweep floor instead of following wave_sel_in.
module wave_sweep_ctrl
    import wave_ctrl_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1_000_000,
    parameter int         DWELL_CYCLES    = 5_000_000,
    parameter logic [7:0] FREQ_MIN        = 8'd1,
    parameter logic [7:0] FREQ_MAX        = 8'd16,
    parameter logic [7:0] FREQ_STEP       = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       dac_done,
    input  logic [1:0] wave_sel_in,
    output logic [7:0] freq_ctrl,
    output logic [1:0] wave_sel,
    output logic       sweep_active,
    output logic       update_pend
);
    localparam int            DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    sweep_state_t  state, state_nx;
    logic          dir_saved, dir_nx;
    logic [DW-1:0] dwell_cnt, cnt_nx;
    logic [7:0]    tgt_freq, freq_nx;
    logic [1:0]    tgt_wave, wave_nx;
    logic          press, terminal, tgt_change;
    logic [9:0]    up_reach, down_floor;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press)
    );

    // Widened compares: a step that would land within one step of a bound clamps to it.
    assign up_reach   = {2'b00, tgt_freq} + {2'b00, FREQ_STEP} + {2'b00, FREQ_STEP};
    assign down_floor = {2'b00, FREQ_MIN} + {2'b00, FREQ_STEP} + {2'b00, FREQ_STEP};
    assign terminal   = (dwell_cnt == DWELL_LAST);

    always_comb begin
        state_nx = state;
        dir_nx   = dir_saved;
        cnt_nx   = dwell_cnt;
        freq_nx  = tgt_freq;
`ifdef WAVE_SWEEP_AUTO_WAVE_EN
        wave_nx  = tgt_wave;
`else
        wave_nx  = legal_wave(wave_sel_in);
`endif
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_nx = ST_SWEEP_UP;
                    cnt_nx   = '0;
                    freq_nx  = FREQ_MIN;
                end
            end
            ST_SWEEP_UP: begin
                // A press beats a dwell terminal: counter freezes and the step waits for resume.
                if (press) begin
                    state_nx = ST_HOLD;
                    dir_nx   = DIR_UP;
                end else if (terminal) begin
                    cnt_nx = '0;
                    if (up_reach > {2'b00, FREQ_MAX}) begin
                        freq_nx  = FREQ_MAX;
                        state_nx = ST_SWEEP_DOWN;
                    end else begin
                        freq_nx = tgt_freq + FREQ_STEP;
                    end
                end else begin
                    cnt_nx = dwell_cnt + 1'b1;
                end
            end
            ST_SWEEP_DOWN: begin
                if (press) begin
                    state_nx = ST_HOLD;
                    dir_nx   = DIR_DOWN;
                end else if (terminal) begin
                    cnt_nx = '0;
                    if ({2'b00, tgt_freq} < down_floor) begin
                        freq_nx  = FREQ_MIN;
                        state_nx = ST_SWEEP_UP;
`ifdef WAVE_SWEEP_AUTO_WAVE_EN
                        wave_nx  = next_wave(tgt_wave);
`endif
                    end else begin
                        freq_nx = tgt_freq - FREQ_STEP;
                    end
                end else begin
                    cnt_nx = dwell_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (press) state_nx = (dir_saved == DIR_UP) ? ST_SWEEP_UP : ST_SWEEP_DOWN;
            end
            default: state_nx = ST_IDLE;
        endcase
        tgt_change = (freq_nx != tgt_freq) || (wave_nx != tgt_wave);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            dir_saved    <= DIR_UP;
            dwell_cnt    <= '0;
            tgt_freq     <= FREQ_MIN;
            tgt_wave     <= WAVE_SINE;
            freq_ctrl    <= FREQ_MIN;
            wave_sel     <= WAVE_SINE;
            sweep_active <= 1'b0;
            update_pend  <= 1'b0;
        end else begin
            state        <= state_nx;
            dir_saved    <= dir_nx;
            dwell_cnt    <= cnt_nx;
            tgt_freq     <= freq_nx;
            tgt_wave     <= wave_nx;
            sweep_active <= (state_nx == ST_SWEEP_UP) || (state_nx == ST_SWEEP_DOWN);
            // Commit the next-target values so a change coinciding with dac_done is not lost.
            if (dac_done && (update_pend || tgt_change)) begin
                freq_ctrl   <= freq_nx;
                wave_sel    <= wave_nx;
                update_pend <= 1'b0;
            end else if (tgt_change) begin
                update_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Bench for wave_sweep_ctrl: directed scenarios plus randomized key/dac/wave/reset traffic,
// checked every cycle against a behavioural model of the sweep and commit rules.
`timescale 1ns/1ps
module tb_wave_sweep_ctrl;
    localparam int DEB   = 4;
    localparam int DWELL = 10;
    localparam int FMIN  = 1;
    localparam int FMAX  = 4;
    localparam int FSTEP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b1;
    logic       dac_done = 1'b0;
    logic [1:0] wave_sel_in = 2'b00;
    logic [7:0] freq_ctrl;
    logic [1:0] wave_sel;
    logic       sweep_active, update_pend;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int dac_mode = 0;
    int dac_div = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wave_sweep_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWELL),
        .FREQ_MIN        (8'(FMIN)),
        .FREQ_MAX        (8'(FMAX)),
        .FREQ_STEP       (8'(FSTEP))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .dac_done     (dac_done),
        .wave_sel_in  (wave_sel_in),
        .freq_ctrl    (freq_ctrl),
        .wave_sel     (wave_sel),
        .sweep_active (sweep_active),
        .update_pend  (update_pend)
    );

    // ---------------- behavioural model ----------------
    int kq[$];
    int deb_lvl, press_q, running, holding, dir, elapsed;
    int tf, tw, of, ow, pend;
    int p, nf, nw, chg, all_diff;
    bit mvalid = 1'b0;

    task automatic model_reset();
        kq.delete();
        for (int i = 0; i < DEB + 2; i++) kq.push_back(1);
        deb_lvl = 1; press_q = 0;
        running = 0; holding = 0; dir = 1; elapsed = 0;
        tf = FMIN; tw = 0; of = FMIN; ow = 0; pend = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            mvalid = 1'b1;
        end else begin
            p  = press_q;
            nf = tf;
            nw = tw;
            if (!running) begin
                if (p != 0) begin running = 1; holding = 0; dir = 1; elapsed = 0; nf = FMIN; end
            end else if (holding != 0) begin
                if (p != 0) holding = 0;
            end else if (p != 0) begin
                holding = 1;
            end else if (elapsed == DWELL - 1) begin
                elapsed = 0;
                if (dir > 0) begin
                    nf = tf + FSTEP;
                    if (nf + FSTEP > FMAX) begin nf = FMAX; dir = -1; end
                end else begin
                    nf = tf - FSTEP;
                    if (nf < FMIN + FSTEP) begin
                        nf = FMIN; dir = 1;
`ifdef WAVE_SWEEP_AUTO_WAVE_EN
                        nw = (tw + 1) % 3;
`endif
                    end
                end
            end else begin
                elapsed++;
            end
`ifndef WAVE_SWEEP_AUTO_WAVE_EN
            nw = (wave_sel_in == 2'b11) ? 0 : int'(wave_sel_in);
`endif
            chg = (nf != tf || nw != tw) ? 1 : 0;
            if (dac_done && (pend != 0 || chg != 0)) begin
                of = nf; ow = nw; pend = 0;
            end else if (chg != 0) begin
                pend = 1;
            end
            tf = nf;
            tw = nw;
            // key seen by the debouncer lags the pin by two samples
            kq.push_front(int'(key));
            if (kq.size() > DEB + 2) void'(kq.pop_back());
            all_diff = 1;
            for (int i = 2; i < DEB + 2; i++) if (kq[i] == deb_lvl) all_diff = 0;
            press_q = 0;
            if (all_diff != 0) begin
                deb_lvl = 1 - deb_lvl;
                press_q = (deb_lvl == 0) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            compared++;
            if (freq_ctrl !== 8'(of) || wave_sel !== 2'(ow) ||
                sweep_active !== (running != 0 && holding == 0) || update_pend !== (pend != 0)) begin
                mismatched++;
                $display("FAIL model_cmp @%0t: freq %0d want %0d, wave %0d want %0d, active %0b want %0b, pend %0b want %0b",
                         $time, freq_ctrl, of, wave_sel, ow, sweep_active,
                         (running != 0 && holding == 0), update_pend, pend);
            end
        end
    end

    // ---------------- commit history ----------------
    int fq[$];
    int last_f = FMIN;
    always @(negedge clk) begin
        if (rst) last_f = FMIN;
        else if (int'(freq_ctrl) != last_f) begin
            fq.push_back(int'(freq_ctrl));
            last_f = int'(freq_ctrl);
        end
    end

    // ---------------- stimulus helpers ----------------
    initial forever begin
        @(posedge clk); #2;
        case (dac_mode)
            1: begin dac_div = (dac_div + 1) % 5; dac_done = (dac_div == 0); end
            2: dac_done = ($urandom_range(0, 3) == 0);
            default: dac_done = 1'b0;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic press_key();
        key = 1'b0; tick(6); key = 1'b1;
    endtask

    int exp_sweep[6] = '{2, 3, 4, 3, 2, 1};
    int f0, n0, ok, khold;

    initial begin
        // reset
        tick(3);
        @(negedge clk);
        chk("reset_freq", int'(freq_ctrl), 1);
        chk("reset_wave", int'(wave_sel), 0);
        chk("reset_active", int'(sweep_active), 0);
        chk("reset_pend", int'(update_pend), 0);
        tick(1);
        rst = 1'b0;
        dac_mode = 1;
        tick(5);

        // bounce: low 2, high 1, low 6 -> one press six samples after the final fall
        key = 1'b0; tick(2); key = 1'b1; tick(1);
        key = 1'b0; f0 = cyc; tick(6); key = 1'b1;
        @(negedge clk);
        chk("bounce_not_yet_active", int'(sweep_active), 0);
        chk("bounce_cycle", cyc - f0, 6);
        @(negedge clk);
        chk("bounce_active", int'(sweep_active), 1);
        fq.delete();

        // full up/down sweep
        repeat (62) @(negedge clk);
        chk("sweep_len", fq.size(), 6);
        for (int i = 0; i < 6 && i < fq.size(); i++) chk($sformatf("sweep_step%0d", i), fq[i], exp_sweep[i]);
`ifdef WAVE_SWEEP_AUTO_WAVE_EN
        chk("floor_wave_adv", int'(wave_sel), 1);
`else
        chk("floor_wave_fixed", int'(wave_sel), 0);
`endif

        // hold while descending at 3
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            if (tf == 3 && dir < 0 && running != 0) ok = 1; else tick(1);
        end
        chk("hold_reach_timeout", ok, 1);
        press_key();
        tick(10);
        @(negedge clk);
        chk("hold_freq", int'(freq_ctrl), 3);
        chk("hold_inactive", int'(sweep_active), 0);
        repeat (30) @(negedge clk);
        chk("hold_freq_30", int'(freq_ctrl), 3);
        fq.delete();
        tick(1);
        press_key();
        ok = 0;
        for (int i = 0; i < 60 && ok == 0; i++) begin
            if (fq.size() >= 2) ok = 1; else @(negedge clk);
        end
        chk("resume_timeout", ok, 1);
        if (fq.size() >= 2) begin
            chk("resume_step0", fq[0], 2);
            chk("resume_step1", fq[1], 1);
        end

        // dac_done starved while sweeping
        tick(1);
        dac_mode = 0;
        n0 = fq.size();
        tick(40);
        @(negedge clk);
        chk("starve_pend", int'(update_pend), 1);
        chk("starve_no_commit", fq.size(), n0);
        tick(1);
        dac_mode = 1;
        tick(12);

`ifndef WAVE_SWEEP_AUTO_WAVE_EN
        wave_sel_in = 2'b10;
        repeat (7) @(negedge clk);
        chk("wave_in_square", int'(wave_sel), 2);
        tick(1);
        wave_sel_in = 2'b11;
        repeat (7) @(negedge clk);
        chk("wave_in_11_sine", int'(wave_sel), 0);
        tick(1);
`endif

        // randomized traffic
        dac_mode = 2;
        khold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (khold == 0) begin
                key = $urandom_range(0, 1) != 0;
                khold = $urandom_range(1, 14);
            end else khold--;
            if ($urandom_range(0, 19) == 0) wave_sel_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1; tick($urandom_range(1, 3)); rst = 1'b0;
            end
            tick(1);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
